// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL bit positions and the STATUS address helper for
// the multi-channel Avalon-MM timer.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_PERIOD  = 2'd1,
    REG_COMPARE = 2'd2,
    REG_COUNT   = 2'd3
  } reg_off_e;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_PINV = 3;
  localparam int CTRL_W    = 4;

  function automatic int status_addr(input int n_ch);
    return 4 * n_ch;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/PERIOD/COMPARE/COUNT registers,
// load/decrement/reload, expiry pulse and registered compare output.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ctrl_we,
  input  logic              period_we,
  input  logic              compare_we,
  input  logic              count_we,
  input  logic [CNT_W-1:0]  wdata,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  compare,
  output logic [CNT_W-1:0]  count,
  output logic              flag_set,
  output logic              pwm_out
);

  logic en, cont, ie, pinv;
  logic expire, en_rise;

  assign ctrl     = {pinv, ie, cont, en};
  assign expire   = en && (count == '0);
  assign flag_set = expire;
  assign en_rise  = ctrl_we && wdata[CTRL_EN] && !en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      cont    <= 1'b0;
      ie      <= 1'b0;
      pinv    <= 1'b0;
      period  <= '0;
      compare <= '0;
      count   <= '0;
      pwm_out <= 1'b0;
    end else begin
      // A software CTRL write overrides the one-shot self-disable.
      if (ctrl_we) begin
        en   <= wdata[CTRL_EN];
        cont <= wdata[CTRL_CONT];
        ie   <= wdata[CTRL_IE];
        pinv <= wdata[CTRL_PINV];
      end else if (expire && !cont) begin
        en <= 1'b0;
      end

      if (period_we)  period  <= wdata;
      if (compare_we) compare <= wdata;

      if (en_rise) begin
        count <= period;
      end else if (count_we) begin
        count <= wdata;
      end else if (en) begin
        if (count != '0) count <= count - CNT_W'(1);
        else if (cont)   count <= period;
      end

      pwm_out <= (en && (count < compare)) ^ pinv;
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Avalon-MM multi-channel timer: address decode, read mux, STATUS
// write-one-to-clear flags and the combined interrupt.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   address,
  input  logic            write,
  input  logic [31:0]     writedata,
  input  logic            read,
  output logic [31:0]     readdata,
  output logic            irq,
  output logic [N_CH-1:0] pwm_out
);

  localparam logic [AW-1:0] STATUS_ADDR = AW'(status_addr(N_CH));

  logic              in_range;
  logic [AW-3:0]     ch_idx;
  reg_off_e          reg_off;
  logic [N_CH-1:0]   flag_set, status, status_clr, ie_vec;
  logic [31:0]       rd_mux;
  logic [CTRL_W-1:0] ctrl    [N_CH];
  logic [CNT_W-1:0]  period  [N_CH];
  logic [CNT_W-1:0]  compare [N_CH];
  logic [CNT_W-1:0]  count   [N_CH];

  assign in_range   = address < STATUS_ADDR;
  assign ch_idx     = address[AW-1:2];
  assign reg_off    = reg_off_e'(address[1:0]);
  assign status_clr = (write && address == STATUS_ADDR) ? writedata[N_CH-1:0] : '0;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic sel;
    assign sel       = write && in_range && (int'(ch_idx) == c);
    assign ie_vec[c] = ctrl[c][CTRL_IE];

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .ctrl_we    (sel && reg_off == REG_CTRL),
      .period_we  (sel && reg_off == REG_PERIOD),
      .compare_we (sel && reg_off == REG_COMPARE),
      .count_we   (sel && reg_off == REG_COUNT),
      .wdata      (writedata[CNT_W-1:0]),
      .ctrl       (ctrl[c]),
      .period     (period[c]),
      .compare    (compare[c]),
      .count      (count[c]),
      .flag_set   (flag_set[c]),
      .pwm_out    (pwm_out[c])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (address == STATUS_ADDR) begin
      rd_mux[N_CH-1:0] = status;
    end else if (in_range) begin
      for (int c = 0; c < N_CH; c++) begin
        if (int'(ch_idx) == c) begin
          case (reg_off)
            REG_CTRL:    rd_mux[CTRL_W-1:0] = ctrl[c];
            REG_PERIOD:  rd_mux[CNT_W-1:0]  = period[c];
            REG_COMPARE: rd_mux[CNT_W-1:0]  = compare[c];
            REG_COUNT:   rd_mux[CNT_W-1:0]  = count[c];
            default:     rd_mux = '0;
          endcase
        end
      end
    end
  end

  // Hardware set is ORed in after the clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status   <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      status <= (status & ~status_clr) | flag_set;
      irq    <= |(status & ie_vec);
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter N_CH, default 4, number of independent timer channels (1..8).
REQ-002 Parameter CNT_W, default 32, counter/period/compare width in bits (8..32).
REQ-003 Parameter AW, default 5, Avalon word-address width; SHALL satisfy 2^AW > 4*N_CH.
REQ-004 clk  in  1  single block clock; all logic is on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 address  in  AW  Avalon-MM slave word address.
REQ-007 write  in  1  write strobe, one cycle per transfer, no waitrequest.
REQ-008 writedata  in  32  write data; bits above CNT_W are ignored.
REQ-009 read  in  1  read strobe.
REQ-010 readdata  out  32  read data, zero-extended above CNT_W.
REQ-011 irq  out  1  level interrupt to the processor.
REQ-012 pwm_out  out  N_CH  per-channel compare output for LEDs or the parallel port.

Function
REQ-013 Channel c SHALL occupy word addresses 4c+0 CTRL, 4c+1 PERIOD, 4c+2 COMPARE, 4c+3 COUNT; address 4*N_CH SHALL be STATUS.
REQ-014 CTRL bits: [0] EN, [1] CONT (1 = auto-reload, 0 = one-shot), [2] IE (interrupt enable), [3] PINV (invert pwm_out); other bits SHALL read 0.
REQ-015 Read latency SHALL be exactly 1 cycle: readdata is registered and valid in the cycle after read; unmapped addresses SHALL read 0.
REQ-016 Writes to unmapped addresses and reads of any register SHALL have no side effects.
REQ-017 A write that takes EN from 0 to 1 SHALL load COUNT with PERIOD in the same edge.
REQ-018 While EN=1 and COUNT>0, COUNT SHALL decrement by 1 each cycle; while EN=0, COUNT SHALL hold.
REQ-019 When EN=1 and COUNT=0, the channel SHALL set its STATUS flag; if CONT=1, COUNT reloads PERIOD; if CONT=0, EN clears and COUNT stays 0.
REQ-020 Writing COUNT SHALL load COUNT with writedata, whatever EN is; this write takes priority over decrement and reload in the same cycle.
REQ-021 Writing PERIOD while running SHALL NOT change COUNT; the new value is used at the next load or reload.
REQ-022 With PERIOD=0 and EN=1: CONT=1 sets the flag every cycle; CONT=0 sets the flag once, then disables.
REQ-023 STATUS[N_CH-1:0] SHALL hold one flag per channel; writing 1 to a bit clears it; writing 0 has no effect.
REQ-024 If a hardware flag set and a software clear hit the same bit in the same cycle, the set SHALL win.
REQ-025 irq SHALL be registered and equal OR over c of (flag[c] AND IE[c]), asserted 1 cycle after the flag sets.
REQ-026 pwm_out[c] SHALL be registered and equal (EN AND COUNT < COMPARE) XOR PINV.
REQ-027 COMPARE=0 SHALL give a constant PINV output; COMPARE > PERIOD SHALL give constant (EN XOR PINV).
REQ-028 All counter arithmetic SHALL be unsigned, CNT_W bits; decrement SHALL never wrap below 0.

Reset
REQ-029 On reset_n low, these SHALL clear asynchronously: all CTRL, PERIOD, COMPARE, COUNT, STATUS, readdata, irq and pwm_out.
REQ-030 Reset mid-count SHALL abandon the count; after release all channels are idle until software sets EN.
REQ-031 Reset deassertion SHALL be synchronised by the instantiating system; the block itself adds no synchroniser.

Structure
REQ-032 A shared package multi_timer_pkg SHALL hold register offsets (CTRL=0, PERIOD=1, COMPARE=2, COUNT=3), CTRL bit indices and the STATUS address function.
REQ-033 Per-channel counter, reload, flag-set and pwm logic SHALL live in one sub-module, timer_channel, instantiated N_CH times by a generate loop.
REQ-034 The top level SHALL hold only address decode, the readdata mux, STATUS W1C merge and the irq OR.

Verification
REQ-035 PERIOD0=4, CTRL0=0b0111 -> COUNT reads 4,3,2,1,0,4 on successive cycles; flag0 set at COUNT=0; irq high 1 cycle later.
REQ-036 PERIOD1=3, CTRL1=0b0001 (one-shot) -> a single flag1; EN1 reads 0 afterwards; COUNT1 holds 0; irq stays 0 because IE=0.
REQ-037 PERIOD2=9, COMPARE2=3, CTRL2=0b0011 -> pwm_out[2] high 3 of every 10 cycles; setting PINV gives 7 of 10.
REQ-038 Write STATUS=0x1 in the same cycle channel 0 reaches COUNT=0 -> flag0 remains 1; a later write of 0x1 clears it and irq drops.
REQ-039 Assert reset_n low mid-count with N_CH=8, CNT_W=16 -> all outputs 0 immediately; after release no channel counts until EN is written.
REQ-040 Read address 4*N_CH+1 -> readdata 0 one cycle later; writes there leave every register unchanged.
